// File: rtl/alu_issue_ctrl_pkg.sv
// alu_issue_ctrl_pkg: shared ALU control codes, issue FSM state encoding and op classification helper.
package alu_issue_ctrl_pkg;

  localparam logic [3:0] CTRL_ALU_ADD  = 4'd0;
  localparam logic [3:0] CTRL_ALU_SUB  = 4'd1;
  localparam logic [3:0] CTRL_ALU_AND  = 4'd2;
  localparam logic [3:0] CTRL_ALU_OR   = 4'd3;
  localparam logic [3:0] CTRL_ALU_SHR  = 4'd4;
  localparam logic [3:0] CTRL_ALU_SHRA = 4'd5;
  localparam logic [3:0] CTRL_ALU_SHL  = 4'd6;
  localparam logic [3:0] CTRL_ALU_ROR  = 4'd7;
  localparam logic [3:0] CTRL_ALU_ROL  = 4'd8;
  localparam logic [3:0] CTRL_ALU_MUL  = 4'd9;
  localparam logic [3:0] CTRL_ALU_DIV  = 4'd10;
  localparam logic [3:0] CTRL_ALU_NEG  = 4'd11;
  localparam logic [3:0] CTRL_ALU_NOT  = 4'd12;

  typedef enum logic [1:0] {
    ISSUE_IDLE = 2'd0,
    ISSUE_EXEC = 2'd1,
    ISSUE_RESP = 2'd2
  } issue_state_e;

  function automatic logic alu_is_muldiv(input logic [3:0] op);
    return (op == CTRL_ALU_MUL) || (op == CTRL_ALU_DIV);
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_settle_timer.sv
// alu_settle_timer: loadable down-counter that saturates at zero; oZero flags the capture cycle.
//   iClk   clock, rising edge
//   nRst   asynchronous active-low reset
//   iLoad  load iVal into the counter (priority over decrement)
//   iVal   load value (settle cycles minus one)
//   oZero  counter is zero
module alu_settle_timer #(
  parameter int unsigned W = 3
) (
  input  logic         iClk,
  input  logic         nRst,
  input  logic         iLoad,
  input  logic [W-1:0] iVal,
  output logic         oZero
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = iLoad ? iVal : (cnt_q != '0 ? cnt_q - W'(1) : cnt_q);
  always_ff @(posedge iClk or negedge nRst)
    if (!nRst) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  assign oZero = (cnt_q == '0);
endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: sequential issuer for the combinational ALU with op-dependent multicycle settle time.
//   Handshake in : iReq/oReady with iOp/iA/iB, iFlush aborts an in-flight op
//   Handshake out: oValid/iAck with oHi/oLo/oZero/oNeg held while valid
//   ALU side     : oAluA/oAluB/oAluCtrl registered drive, iAluHi/iAluLo/iAluZero/iAluNeg results
//   Flags        : oFlagZ/oFlagN sticky on capture when ALU_FLAGS_EN is defined, else tied to 0
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int unsigned SETTLE_FAST   = 1,
  parameter int unsigned SETTLE_MULDIV = 4
) (
  input  logic        iClk,
  input  logic        nRst,
  input  logic        iReq,
  input  logic [3:0]  iOp,
  input  logic [31:0] iA,
  input  logic [31:0] iB,
  output logic        oReady,
  input  logic        iFlush,
  output logic        oValid,
  input  logic        iAck,
  output logic [31:0] oHi,
  output logic [31:0] oLo,
  output logic        oZero,
  output logic        oNeg,
  output logic [31:0] oAluA,
  output logic [31:0] oAluB,
  output logic [3:0]  oAluCtrl,
  input  logic [31:0] iAluHi,
  input  logic [31:0] iAluLo,
  input  logic        iAluZero,
  input  logic        iAluNeg,
  output logic        oFlagZ,
  output logic        oFlagN
);
  localparam int unsigned W = $clog2(SETTLE_MULDIV + 1);

  issue_state_e state_q, state_d;
  logic [31:0]  a_q, b_q, hi_q, lo_q;
  logic [3:0]   ctrl_q;
  logic         zero_q, neg_q;
  logic         accept, capture, tmr_zero;
  logic [W-1:0] settle;

  // counter is loaded with S-1 so that it reads zero on the final settle cycle
  assign settle = alu_is_muldiv(iOp) ? W'(SETTLE_MULDIV - 1) : W'(SETTLE_FAST - 1);

  alu_settle_timer #(.W(W)) u_timer (
    .iClk (iClk),
    .nRst (nRst),
    .iLoad(accept),
    .iVal (settle),
    .oZero(tmr_zero)
  );

  // flush outranks both capture and ack
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    capture = 1'b0;
    case (state_q)
      ISSUE_IDLE: if (iReq) begin
        accept  = 1'b1;
        state_d = ISSUE_EXEC;
      end
      ISSUE_EXEC: if (iFlush) state_d = ISSUE_IDLE;
                  else if (tmr_zero) begin
                    capture = 1'b1;
                    state_d = ISSUE_RESP;
                  end
      ISSUE_RESP: if (iFlush || iAck) state_d = ISSUE_IDLE;
      default:    state_d = ISSUE_IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge nRst)
    if (!nRst) state_q <= ISSUE_IDLE;
    else       state_q <= state_d;

  always_ff @(posedge iClk or negedge nRst)
    if (!nRst) begin
      a_q    <= '0;
      b_q    <= '0;
      ctrl_q <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
    end else begin
      if (accept) begin
        a_q    <= iA;
        b_q    <= iB;
        ctrl_q <= iOp;
      end
      if (capture) begin
        hi_q   <= iAluHi;
        lo_q   <= iAluLo;
        zero_q <= iAluZero;
        neg_q  <= iAluNeg;
      end
    end

`ifdef ALU_FLAGS_EN
  logic flag_z_q, flag_n_q;
  always_ff @(posedge iClk or negedge nRst)
    if (!nRst) begin
      flag_z_q <= 1'b0;
      flag_n_q <= 1'b0;
    end else if (capture) begin
      flag_z_q <= iAluZero;
      flag_n_q <= iAluNeg;
    end
  assign oFlagZ = flag_z_q;
  assign oFlagN = flag_n_q;
`else
  assign oFlagZ = 1'b0;
  assign oFlagN = 1'b0;
`endif

  assign oReady   = (state_q == ISSUE_IDLE);
  assign oValid   = (state_q == ISSUE_RESP);
  assign oAluA    = a_q;
  assign oAluB    = b_q;
  assign oAluCtrl = ctrl_q;
  assign oHi      = hi_q;
  assign oLo      = lo_q;
  assign oZero    = zero_q;
  assign oNeg     = neg_q;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed plus randomized checks of alu_issue_ctrl against a transaction-level model.
module tb_alu_issue_ctrl;
  import alu_issue_ctrl_pkg::*;

  localparam int SF = 1;
  localparam int SM = 4;

  logic        iClk = 1'b0, nRst = 1'b0, iReq = 1'b0, iFlush = 1'b0, iAck = 1'b0;
  logic [3:0]  iOp = '0;
  logic [31:0] iA = '0, iB = '0;
  logic        oReady, oValid, oZero, oNeg, oFlagZ, oFlagN;
  logic [31:0] oHi, oLo, oAluA, oAluB;
  logic [3:0]  oAluCtrl;
  logic [31:0] iAluHi, iAluLo;
  logic        iAluZero, iAluNeg;

  int errors = 0, checks = 0;
  logic [31:0] last_hi = '0, last_lo = '0;
  logic        last_z = 1'b0, last_n = 1'b0, fz = 1'b0, fn = 1'b0;

  alu_issue_ctrl #(.SETTLE_FAST(SF), .SETTLE_MULDIV(SM)) dut (
    .iClk(iClk), .nRst(nRst), .iReq(iReq), .iOp(iOp), .iA(iA), .iB(iB),
    .oReady(oReady), .iFlush(iFlush), .oValid(oValid), .iAck(iAck),
    .oHi(oHi), .oLo(oLo), .oZero(oZero), .oNeg(oNeg),
    .oAluA(oAluA), .oAluB(oAluB), .oAluCtrl(oAluCtrl),
    .iAluHi(iAluHi), .iAluLo(iAluLo), .iAluZero(iAluZero), .iAluNeg(iAluNeg),
    .oFlagZ(oFlagZ), .oFlagN(oFlagN)
  );

  always #5 iClk = ~iClk;

  function automatic logic [63:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [4:0]  s;
    logic [63:0] p;
    s = b[4:0];
    p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    case (op)
      CTRL_ALU_ADD:  return {32'd0, a + b};
      CTRL_ALU_SUB:  return {32'd0, a - b};
      CTRL_ALU_AND:  return {32'd0, a & b};
      CTRL_ALU_OR:   return {32'd0, a | b};
      CTRL_ALU_SHR:  return {32'd0, a >> s};
      CTRL_ALU_SHRA: return {32'd0, 32'($signed(a) >>> s)};
      CTRL_ALU_SHL:  return {32'd0, a << s};
      CTRL_ALU_ROR:  return {32'd0, (a >> s) | (a << (6'd32 - {1'b0, s}))};
      CTRL_ALU_ROL:  return {32'd0, (a << s) | (a >> (6'd32 - {1'b0, s}))};
      CTRL_ALU_MUL:  return p;
      CTRL_ALU_DIV:  return (b == 0) ? 64'd0 : {a % b, a / b};
      CTRL_ALU_NEG:  return {32'd0, -a};
      CTRL_ALU_NOT:  return {32'd0, ~a};
      default:       return 64'd0;
    endcase
  endfunction

  // the ALU this block drives: purely combinational
  always_comb begin
    {iAluHi, iAluLo} = alu_ref(oAluCtrl, oAluA, oAluB);
    iAluZero = (iAluLo == 32'd0);
    iAluNeg  = iAluLo[31];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge iClk);
    #1;
  endtask

  task automatic chk_res(input string tag);
    chk({tag, "_hi"}, oHi, last_hi);
    chk({tag, "_lo"}, oLo, last_lo);
    chk({tag, "_zero"}, oZero, last_z);
    chk({tag, "_neg"}, oNeg, last_n);
`ifdef ALU_FLAGS_EN
    chk({tag, "_flagz"}, oFlagZ, fz);
    chk({tag, "_flagn"}, oFlagN, fn);
`else
    chk({tag, "_flagz"}, oFlagZ, 1'b0);
    chk({tag, "_flagn"}, oFlagN, 1'b0);
`endif
  endtask

  function automatic int settle_of(input logic [3:0] op);
    return (op == CTRL_ALU_MUL || op == CTRL_ALU_DIV) ? SM : SF;
  endfunction

  task automatic model_capture(input logic [63:0] r);
    last_hi = r[63:32];
    last_lo = r[31:0];
    last_z  = (r[31:0] == 32'd0);
    last_n  = r[31];
    fz = last_z;
    fn = last_n;
  endtask

  // flush_cyc: 0 = none, n in 1..S = assert iFlush during the n-th EXEC cycle
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int hold, input int flush_cyc);
    logic [63:0] r;
    int s, lat;
    r = alu_ref(op, a, b);
    s = settle_of(op);
    lat = 0;
    while (!oReady && lat < 20) begin tick; lat++; end
    iReq = 1'b1; iOp = op; iA = a; iB = b;
    tick;
    iReq = 1'b0; iOp = 4'($urandom); iA = $urandom; iB = $urandom;
    chk({tag, "_alua"}, oAluA, a);
    chk({tag, "_ctrl"}, oAluCtrl, op);
    chk({tag, "_busy"}, oReady, 1'b0);
    if (flush_cyc > 0 && flush_cyc <= s) begin
      repeat (flush_cyc - 1) tick;
      iFlush = 1'b1;
      tick;
      iFlush = 1'b0;
      chk({tag, "_fl_ready"}, oReady, 1'b1);
      chk({tag, "_fl_valid"}, oValid, 1'b0);
      chk_res({tag, "_fl_kept"});
      lat = 0;
      repeat (s + 1) begin tick; lat += int'(oValid); end
      chk({tag, "_fl_novalid"}, lat, 0);
    end else begin
      lat = 0;
      while (!oValid && lat < 20) begin tick; lat++; end
      chk({tag, "_latency"}, lat, s);
      model_capture(r);
      chk_res(tag);
      chk({tag, "_alub"}, oAluB, b);
      repeat (hold) begin
        tick;
        chk({tag, "_hold_valid"}, oValid, 1'b1);
        chk({tag, "_hold_lo"}, oLo, last_lo);
      end
      iAck = 1'b1;
      tick;
      iAck = 1'b0;
      chk({tag, "_ack_valid"}, oValid, 1'b0);
      chk({tag, "_ack_ready"}, oReady, 1'b1);
    end
  endtask

  initial begin
    logic [63:0] r;
    int lat;
    repeat (2) @(posedge iClk);
    #1;
    chk("rst_ready", oReady, 1'b1);
    chk("rst_valid", oValid, 1'b0);
    chk("rst_alua", oAluA, 32'd0);
    chk("rst_ctrl", oAluCtrl, 4'd0);
    chk_res("rst");
    nRst = 1'b1;
    tick;

    run_op("add", CTRL_ALU_ADD, 32'd5, 32'd7, 0, 0);
    chk("add_lo12", oLo, 32'd12);
    run_op("mul", CTRL_ALU_MUL, 32'h0001_0000, 32'h0001_0000, 1, 0);
    chk("mul_hi1", oHi, 32'd1);
    run_op("sub", CTRL_ALU_SUB, 32'd3, 32'd3, 3, 0);
    chk("sub_zero", oZero, 1'b1);
    run_op("unk", 4'hF, 32'hDEAD_BEEF, 32'h1234_5678, 0, 0);
    run_op("neg", CTRL_ALU_NEG, 32'd1, 32'd0, 1, 0);
    run_op("divfl", CTRL_ALU_DIV, 32'd100, 32'd7, 0, 2);

    // flush and ack together in RESP: flush wins, result registers kept
    iReq = 1'b1; iOp = CTRL_ALU_ADD; iA = 32'd10; iB = 32'd20;
    tick;
    iReq = 1'b0;
    tick;
    chk("rfl_valid", oValid, 1'b1);
    model_capture(64'd30);
    chk_res("rfl");
    iFlush = 1'b1; iAck = 1'b1;
    tick;
    iFlush = 1'b0; iAck = 1'b0;
    chk("rfl_idle", oReady, 1'b1);
    chk("rfl_novalid", oValid, 1'b0);
    chk_res("rfl_kept");

    // flush in IDLE does not block an accept
    iFlush = 1'b1; iReq = 1'b1; iOp = CTRL_ALU_ADD; iA = 32'd2; iB = 32'd2;
    tick;
    iFlush = 1'b0; iReq = 1'b0;
    chk("ifl_busy", oReady, 1'b0);
    chk("ifl_alua", oAluA, 32'd2);
    tick;
    model_capture(64'd4);
    chk("ifl_valid", oValid, 1'b1);
    chk_res("ifl");
    iAck = 1'b1;
    tick;
    iAck = 1'b0;

    // iReq while busy is ignored, ALU inputs stay put, one result only
    iReq = 1'b1; iOp = CTRL_ALU_MUL; iA = 32'd9; iB = 32'd3;
    tick;
    lat = 0;
    while (!oValid && lat < 20) begin
      iA = $urandom; iOp = CTRL_ALU_ADD;
      tick;
      chk("busy_alua", oAluA, 32'd9);
      lat++;
    end
    chk("busy_latency", lat, SM);
    model_capture(alu_ref(CTRL_ALU_MUL, 32'd9, 32'd3));
    chk_res("busy");
    repeat (2) begin
      tick;
      chk("resp_alua", oAluA, 32'd9);
      chk("resp_ctrl", oAluCtrl, CTRL_ALU_MUL);
      chk("resp_valid", oValid, 1'b1);
    end
    iReq = 1'b0; iAck = 1'b1;
    tick;
    iAck = 1'b0;
    lat = 0;
    repeat (4) begin tick; lat += int'(oValid); end
    chk("busy_one_result", lat, 0);
    chk("busy_idle", oReady, 1'b1);

    // asynchronous reset in the middle of EXEC
    iReq = 1'b1; iOp = CTRL_ALU_DIV; iA = 32'd100; iB = 32'd7;
    tick;
    iReq = 1'b0;
    tick;
    #2 nRst = 1'b0;
    #1;
    last_hi = '0; last_lo = '0; last_z = 1'b0; last_n = 1'b0; fz = 1'b0; fn = 1'b0;
    chk("arst_ready", oReady, 1'b1);
    chk("arst_valid", oValid, 1'b0);
    chk("arst_alua", oAluA, 32'd0);
    chk("arst_alub", oAluB, 32'd0);
    chk("arst_ctrl", oAluCtrl, 4'd0);
    chk_res("arst");
    #2 nRst = 1'b1;
    tick;

    for (int i = 0; i < 40; i++) begin
      logic [3:0] op;
      op = 4'($urandom_range(0, 15));
      r = {$urandom, $urandom};
      run_op("rnd", op, r[63:32], r[31:0], $urandom_range(0, 3),
             ($urandom_range(0, 4) == 0) ? $urandom_range(1, SM) : 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
